decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipeline stage directly downstream of the fetch stage.
- Accepts fetch-to-decode packets (exec mask, PC, 32-bit instruction word) through a valid/ready handshake and buffers them in a small input FIFO.
- Splits each instruction into opcode, register and immediate fields, classifies it, and presents a registered decoded packet to the execute stage.
- Tracks HALT, flags illegal opcodes, and counts back-pressure stall cycles for the performance counters.

Parameters:
- ADDR_W, 64: width of memory_address_t (PC).
- NUM_THREADS, 8: width of execution_mask_t.
- INSN_W, 32: width of instruction_t.
- FIFO_DEPTH, 2: input FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  stage clock.
- reset  in  1  synchronous, active-high reset.
- fetch_valid  in  1  fetch presents a packet.
- fetch_ready  out  1  decode can accept; equals FIFO not full and state RUN.
- fetch_exec_mask  in  NUM_THREADS  packet exec mask.
- fetch_pc  in  ADDR_W  packet PC.
- fetch_insn  in  INSN_W  packet instruction word.
- dec_valid  out  1  decoded packet valid.
- dec_ready  in  1  execute accepts.
- dec_exec_mask  out  NUM_THREADS  forwarded mask.
- dec_pc  out  ADDR_W  forwarded PC.
- dec_opcode  out  8  insn[7:0].
- dec_rd  out  4  insn[11:8].
- dec_rs1  out  4  insn[15:12].
- dec_rs2  out  4  insn[19:16].
- dec_imm  out  64  insn[31:16] sign-extended.
- dec_is_branch  out  1  JMP_ALWAYS/EQUAL/NOT_EQUAL/GREATER/GREATER_EQUAL/LOWER/LOWER_EQUAL.
- dec_is_ctrl  out  1  changes control flow: branch, HALT or LOAD_RESTORE_PC.
- dec_illegal  out  1  opcode > OPCODE_MAX.
- halted  out  1  HALT has been handed to execute.
- stall_count  out  32  saturating count of dec_valid && !dec_ready cycles.

Behaviour:
- Reset values: all outputs 0; FIFO empty with pointers 0; state RUN; stall_count 0. fetch_ready is 1 the cycle after reset deasserts. Reset mid-operation discards all buffered and output packets in the same edge.
- Push: fetch_valid && fetch_ready writes {mask, pc, insn} at the write pointer. Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. full = MSBs differ and low bits equal; empty = pointers equal.
- fetch_ready = !full && state==RUN. There is no full-bypass: when the FIFO is full, a push is refused even if a pop happens in the same cycle.
- Output register load condition: (!dec_valid || dec_ready) && !empty. On load, pop the FIFO head, register decoded fields, set dec_valid=1.
- If dec_valid && dec_ready && empty: dec_valid goes 0 next cycle.
- Latency: a packet accepted into an empty FIFO with an idle output appears on dec_valid the next cycle (1 cycle).
- Throughput: 1 packet/cycle while dec_ready=1.
- Output hold: fields are stable while dec_valid && !dec_ready.
- Simultaneous push and pop on a non-full FIFO: both occur; occupancy unchanged.
- Decoding is purely combinational from the FIFO head and registered into the output.
- dec_illegal packets are still forwarded; execute raises the fault.
- State machine:
  - RUN: normal operation. When the output register loads a HALT opcode, go to HALT_DRAIN.
  - HALT_DRAIN: fetch_ready=0; entries still in the FIFO (younger than HALT) are dropped. When the HALT packet handshakes (dec_valid && dec_ready), clear the FIFO and go to HALTED.
  - HALTED: halted=1, fetch_ready=0, dec_valid=0. Only reset leaves this state.
- stall_count: increments each cycle with dec_valid && !dec_ready; saturates at 0xFFFF_FFFF with no wrap.

Decomposition:
- Shared package (existing, extended):
  - Opcode enum with OPCODE_MAX.
  - instruction_t, memory_address_t, execution_mask_t.
  - FetchToDecodeBusPacket struct.
  - New DecodeToExecutePacket struct.
  - Field position constants: OPC_LSB, RD_LSB, RS1_LSB, RS2_LSB, IMM_LSB.
  - changesControlFlow and a new isBranch function.
- One sub-module, decode_fifo (parameterised sync FIFO, push/pop/full/empty, reset clears).
- Decode logic, FSM and counters stay in decode_stage.

Test Plan:
- Reset with fetch_valid=1 → all outputs 0; fetch_ready rises 1 cycle after reset falls; nothing is accepted during reset.
- Single ADD-class insn 0xFFFE_4321 at pc=0x100, mask=0xFF, dec_ready=1 → next cycle dec_valid=1, opcode=0x21, rd=3, rs1=4, rs2=0xE, imm=0xFFFF_FFFF_FFFF_FFFE, is_branch=0.
- Stream of 4 packets with dec_ready=0 → 1 packet in the output register plus 2 in the FIFO, then fetch_ready=0. After 5 stalled cycles stall_count=5. Raising dec_ready drains the packets in order with no loss or duplicate.
- JMP_EQUAL word → dec_is_branch=1, dec_is_ctrl=1. LOAD_RESTORE_PC word → is_ctrl=1, is_branch=0.
- HALT followed by one younger packet, dec_ready=1 → HALT forwarded; the younger packet is never output; halted=1 and fetch_ready=0 thereafter. Reset returns the block to RUN.
- Opcode OPCODE_MAX+1 → forwarded with dec_illegal=1. stall_count preloaded near 0xFFFF_FFFF with a long stall → value holds at 0xFFFF_FFFF.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared fetch/decode types, opcodes, field positions and decode helpers
//
// Purpose: common definitions for the fetch->decode->execute path.
//   Opcode enum (with OPCODE_MAX), instruction/address/mask types,
//   FetchToDecodeBusPacket, DecodeToExecutePacket, instruction field
//   positions, and the isBranch / changesControlFlow classifiers.
// Ports: none (package).
package decode_stage_pkg;

    localparam int MEM_ADDR_W  = 64;
    localparam int EXEC_MASK_W = 8;
    localparam int INSN_WIDTH  = 32;

    typedef logic [INSN_WIDTH-1:0]  instruction_t;
    typedef logic [MEM_ADDR_W-1:0]  memory_address_t;
    typedef logic [EXEC_MASK_W-1:0] execution_mask_t;

    typedef enum logic [7:0] {
        OP_NOP                = 8'h00,
        OP_HALT               = 8'h01,
        OP_LOAD_RESTORE_PC    = 8'h02,
        OP_JMP_ALWAYS         = 8'h10,
        OP_JMP_EQUAL          = 8'h11,
        OP_JMP_NOT_EQUAL      = 8'h12,
        OP_JMP_GREATER        = 8'h13,
        OP_JMP_GREATER_EQUAL  = 8'h14,
        OP_JMP_LOWER          = 8'h15,
        OP_JMP_LOWER_EQUAL    = 8'h16,
        OP_ADD                = 8'h21,
        OP_SUB                = 8'h22,
        OP_AND                = 8'h23,
        OP_OR                 = 8'h24,
        OP_XOR                = 8'h25,
        OP_SHL                = 8'h26,
        OP_SHR                = 8'h27,
        OP_LOAD               = 8'h30,
        OP_STORE              = 8'h31
    } opcode_e;

    // Highest defined opcode; anything above is forwarded but flagged illegal.
    localparam logic [7:0] OPCODE_MAX = 8'h31;

    // Instruction word layout.
    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 12;
    localparam int RS2_LSB = 16;
    localparam int IMM_LSB = 16;

    typedef struct packed {
        execution_mask_t exec_mask;
        memory_address_t pc;
        instruction_t    insn;
    } FetchToDecodeBusPacket;

    typedef struct packed {
        execution_mask_t exec_mask;
        memory_address_t pc;
        logic [7:0]      opcode;
        logic [3:0]      rd;
        logic [3:0]      rs1;
        logic [3:0]      rs2;
        logic [63:0]     imm;
        logic            is_branch;
        logic            is_ctrl;
        logic            illegal;
    } DecodeToExecutePacket;

    function automatic logic isBranch(input logic [7:0] opc);
        logic r;
        case (opc)
            OP_JMP_ALWAYS,
            OP_JMP_EQUAL,
            OP_JMP_NOT_EQUAL,
            OP_JMP_GREATER,
            OP_JMP_GREATER_EQUAL,
            OP_JMP_LOWER,
            OP_JMP_LOWER_EQUAL: r = 1'b1;
            default:            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic changesControlFlow(input logic [7:0] opc);
        return isBranch(opc) || (opc == OP_HALT) || (opc == OP_LOAD_RESTORE_PC);
    endfunction

endpackage

// File: rtl/decode_fifo.sv
// rtl/decode_fifo.sv - small synchronous FIFO buffering fetch packets ahead of decode
//
// Purpose: parameterised sync FIFO with extra-bit wrap pointers.
// Ports:
//   clk_i        in   clock
//   reset_i      in   synchronous active-high reset, empties the FIFO
//   clear_i      in   synchronous flush, empties the FIFO
//   push_i       in   write push_data_i (ignored when full)
//   push_data_i  in   WIDTH write data
//   pop_i        in   drop head entry (ignored when empty)
//   head_data_o  out  WIDTH entry at the read pointer
//   full_o       out  FIFO holds DEPTH entries
//   empty_o      out  FIFO holds no entries
module decode_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    // The extra MSB distinguishes full from empty when the index bits match.
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign head_data_o = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    // Storage needs no reset: an entry is only observed once it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode pipeline stage between fetch and execute
//
// Purpose: buffers fetch packets, splits/classifies instructions, registers
//   the decoded packet for execute, tracks HALT and counts stall cycles.
// Ports:
//   clk, reset                       stage clock, synchronous active-high reset
//   fetch_valid/fetch_ready          fetch handshake
//   fetch_exec_mask/pc/insn          incoming packet
//   dec_valid/dec_ready              execute handshake
//   dec_exec_mask/pc                 forwarded mask and PC
//   dec_opcode/rd/rs1/rs2/imm        instruction fields (imm sign-extended)
//   dec_is_branch/is_ctrl/illegal    classification
//   halted                           HALT has been handed to execute
//   stall_count                      saturating count of back-pressure cycles
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int NUM_THREADS = EXEC_MASK_W,
    parameter int INSN_W      = INSN_WIDTH,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch_valid,
    output logic                   fetch_ready,
    input  logic [NUM_THREADS-1:0] fetch_exec_mask,
    input  logic [ADDR_W-1:0]      fetch_pc,
    input  logic [INSN_W-1:0]      fetch_insn,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [NUM_THREADS-1:0] dec_exec_mask,
    output logic [ADDR_W-1:0]      dec_pc,
    output logic [7:0]             dec_opcode,
    output logic [3:0]             dec_rd,
    output logic [3:0]             dec_rs1,
    output logic [3:0]             dec_rs2,
    output logic [63:0]            dec_imm,
    output logic                   dec_is_branch,
    output logic                   dec_is_ctrl,
    output logic                   dec_illegal,
    output logic                   halted,
    output logic [31:0]            stall_count
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_HALT_DRAIN = 2'd1,
        ST_HALTED     = 2'd2
    } state_e;

    state_e                state_q;
    logic                  alive_q;
    logic                  out_valid_q;
    logic                  halted_q;
    DecodeToExecutePacket  out_q;
    DecodeToExecutePacket  dec_d;
    logic [31:0]           stall_count_q;

    FetchToDecodeBusPacket push_pkt;
    FetchToDecodeBusPacket head_pkt;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  load;
    logic                  handshake;
    logic                  fifo_clear;

    // alive_q holds fetch_ready low for the first cycle after reset releases.
    assign fetch_ready = alive_q && !fifo_full && (state_q == ST_RUN);
    assign push        = fetch_valid && fetch_ready;
    assign handshake   = out_valid_q && dec_ready;

    // Only RUN pops; in HALT_DRAIN the FIFO holds packets younger than HALT.
    assign load       = (state_q == ST_RUN) && (!out_valid_q || dec_ready) && !fifo_empty;
    assign fifo_clear = (state_q == ST_HALT_DRAIN) && handshake;

    assign push_pkt.exec_mask = fetch_exec_mask;
    assign push_pkt.pc        = fetch_pc;
    assign push_pkt.insn      = fetch_insn;

    decode_fifo #(
        .WIDTH ($bits(FetchToDecodeBusPacket)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .reset_i     (reset),
        .clear_i     (fifo_clear),
        .push_i      (push),
        .push_data_i (push_pkt),
        .pop_i       (load),
        .head_data_o (head_pkt),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        dec_d           = '0;
        dec_d.exec_mask = head_pkt.exec_mask;
        dec_d.pc        = head_pkt.pc;
        dec_d.opcode    = head_pkt.insn[OPC_LSB +: 8];
        dec_d.rd        = head_pkt.insn[RD_LSB +: 4];
        dec_d.rs1       = head_pkt.insn[RS1_LSB +: 4];
        dec_d.rs2       = head_pkt.insn[RS2_LSB +: 4];
        dec_d.imm       = {{48{head_pkt.insn[IMM_LSB + 15]}}, head_pkt.insn[IMM_LSB +: 16]};
        dec_d.is_branch = isBranch(dec_d.opcode);
        dec_d.is_ctrl   = changesControlFlow(dec_d.opcode);
        dec_d.illegal   = (dec_d.opcode > OPCODE_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            alive_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            halted_q    <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            case (state_q)
                ST_RUN: begin
                    if (load) begin
                        out_q       <= dec_d;
                        out_valid_q <= 1'b1;
                        if (dec_d.opcode == OP_HALT) begin
                            state_q <= ST_HALT_DRAIN;
                        end
                    end else if (handshake) begin
                        out_valid_q <= 1'b0;
                    end
                end
                ST_HALT_DRAIN: begin
                    if (handshake) begin
                        out_valid_q <= 1'b0;
                        halted_q    <= 1'b1;
                        state_q     <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    out_valid_q <= 1'b0;
                    halted_q    <= 1'b1;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else if (out_valid_q && !dec_ready && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign dec_valid     = out_valid_q;
    assign dec_exec_mask = out_q.exec_mask;
    assign dec_pc        = out_q.pc;
    assign dec_opcode    = out_q.opcode;
    assign dec_rd        = out_q.rd;
    assign dec_rs1       = out_q.rs1;
    assign dec_rs2       = out_q.rs2;
    assign dec_imm       = out_q.imm;
    assign dec_is_branch = out_q.is_branch;
    assign dec_is_ctrl   = out_q.is_ctrl;
    assign dec_illegal   = out_q.illegal;
    assign halted        = halted_q;
    assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized and directed bench for decode_stage against a queue-based model
module tb_decode_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [7:0]  fetch_exec_mask;
    logic [63:0] fetch_pc;
    logic [31:0] fetch_insn;
    logic        dec_valid;
    logic        dec_ready;
    logic [7:0]  dec_exec_mask;
    logic [63:0] dec_pc;
    logic [7:0]  dec_opcode;
    logic [3:0]  dec_rd;
    logic [3:0]  dec_rs1;
    logic [3:0]  dec_rs2;
    logic [63:0] dec_imm;
    logic        dec_is_branch;
    logic        dec_is_ctrl;
    logic        dec_illegal;
    logic        halted;
    logic [31:0] stall_count;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .fetch_exec_mask (fetch_exec_mask),
        .fetch_pc        (fetch_pc),
        .fetch_insn      (fetch_insn),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_exec_mask   (dec_exec_mask),
        .dec_pc          (dec_pc),
        .dec_opcode      (dec_opcode),
        .dec_rd          (dec_rd),
        .dec_rs1         (dec_rs1),
        .dec_rs2         (dec_rs2),
        .dec_imm         (dec_imm),
        .dec_is_branch   (dec_is_branch),
        .dec_is_ctrl     (dec_is_ctrl),
        .dec_illegal     (dec_illegal),
        .halted          (halted),
        .stall_count     (stall_count)
    );

    typedef struct packed {
        logic [7:0]  mask;
        logic [63:0] pc;
        logic [31:0] insn;
    } pkt_t;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: FIFO contents, output slot, run/drain/halted phase.
    pkt_t        m_fifo[$];
    pkt_t        m_out;
    bit          m_out_valid = 0;
    bit          m_zero = 1;
    int          m_state = 0;
    bit          m_alive = 0;
    logic [31:0] m_stall = '0;
    bit          skip_stall = 0;

    pkt_t        stim_q[$];
    logic [63:0] obs_pcs[$];
    int          vprob = 100;
    int          rprob = 100;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] f_opc(input logic [31:0] w);
        return 8'(w & 32'hFF);
    endfunction

    function automatic bit f_branch(input logic [7:0] o);
        return (o >= 8'h10) && (o <= 8'h16);
    endfunction

    function automatic bit f_ctrl(input logic [7:0] o);
        return f_branch(o) || (o == 8'h01) || (o == 8'h02);
    endfunction

    function automatic logic [63:0] f_imm(input logic [31:0] w);
        int si;
        si = int'(w);
        return 64'(longint'(si >>> 16));
    endfunction

    function automatic pkt_t mk(input logic [7:0] m, input logic [63:0] pc, input logic [31:0] w);
        pkt_t p;
        p.mask = m;
        p.pc   = pc;
        p.insn = w;
        return p;
    endfunction

    function automatic pkt_t rand_pkt();
        logic [31:0] w;
        w = $urandom;
        w[7:0] = ($urandom_range(99) < 3) ? 8'h01 : 8'($urandom_range(8'h3F));
        return mk(8'($urandom), {$urandom, $urandom}, w);
    endfunction

    task automatic model_edge(input bit rst, input bit fv, input pkt_t fin, input bit dr);
        bit ready;
        bit hs;
        bit stall;
        if (rst) begin
            m_fifo.delete();
            m_out       = '0;
            m_out_valid = 0;
            m_zero      = 1;
            m_state     = 0;
            m_alive     = 0;
            m_stall     = '0;
        end else begin
            ready = m_alive && (m_fifo.size() < DEPTH) && (m_state == 0);
            hs    = m_out_valid && dr;
            stall = m_out_valid && !dr;
            if (m_state == 0) begin
                if ((!m_out_valid || dr) && (m_fifo.size() > 0)) begin
                    m_out       = m_fifo.pop_front();
                    m_out_valid = 1;
                    m_zero      = 0;
                    if (f_opc(m_out.insn) == 8'h01) m_state = 1;
                end else if (hs) begin
                    m_out_valid = 0;
                end
            end else if (m_state == 1) begin
                if (hs) begin
                    m_out_valid = 0;
                    m_fifo.delete();
                    m_state = 2;
                end
            end
            if (ready && fv) m_fifo.push_back(fin);
            if (stall && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
            m_alive = 1;
        end
    endtask

    task automatic compare_all();
        bit exp_ready;
        exp_ready = m_alive && (m_fifo.size() < DEPTH) && (m_state == 0);
        check_eq("dec_valid", dec_valid, m_out_valid);
        check_eq("fetch_ready", fetch_ready, exp_ready);
        check_eq("halted", halted, m_state == 2);
        if (!skip_stall) check_eq("stall_count", stall_count, m_stall);
        if (m_out_valid || m_zero) begin
            check_eq("mask", dec_exec_mask, m_out.mask);
            check_eq("pc", dec_pc, m_out.pc);
            check_eq("opcode", dec_opcode, f_opc(m_out.insn));
            check_eq("rd", dec_rd, (m_out.insn >> 8) & 32'hF);
            check_eq("rs1", dec_rs1, (m_out.insn >> 12) & 32'hF);
            check_eq("rs2", dec_rs2, (m_out.insn >> 16) & 32'hF);
            check_eq("imm", dec_imm, m_zero ? 64'd0 : f_imm(m_out.insn));
            check_eq("is_branch", dec_is_branch, f_branch(f_opc(m_out.insn)));
            check_eq("is_ctrl", dec_is_ctrl, f_ctrl(f_opc(m_out.insn)));
            check_eq("illegal", dec_illegal, f_opc(m_out.insn) > 8'h31);
        end
    endtask

    task automatic drive();
        fetch_valid     = 1'b0;
        fetch_exec_mask = 8'($urandom);
        fetch_pc        = {$urandom, $urandom};
        fetch_insn      = $urandom;
        if ((stim_q.size() > 0) && (int'($urandom_range(99)) < vprob)) begin
            fetch_valid = 1'b1;
            {fetch_exec_mask, fetch_pc, fetch_insn} = stim_q[0];
        end
        dec_ready = (int'($urandom_range(99)) < rprob);
    endtask

    task automatic cycle();
        bit          rst;
        bit          fv;
        bit          dr;
        bit          acc;
        bit          hs;
        logic [63:0] pc_now;
        pkt_t        fin;
        rst    = reset;
        fv     = fetch_valid;
        dr     = dec_ready;
        fin    = {fetch_exec_mask, fetch_pc, fetch_insn};
        acc    = fetch_valid && fetch_ready && !reset;
        hs     = dec_valid && dec_ready && !reset;
        pc_now = dec_pc;
        @(posedge clk);
        model_edge(rst, fv, fin, dr);
        if (hs) obs_pcs.push_back(pc_now);
        #1;
        compare_all();
        if (acc && (stim_q.size() > 0)) void'(stim_q.pop_front());
        drive();
    endtask

    task automatic do_reset();
        int old_v;
        old_v = vprob;
        vprob = 100;
        reset = 1'b1;
        stim_q.delete();
        stim_q.push_back(rand_pkt());
        drive();
        repeat (2) cycle();
        check_eq("rst_dec_valid", dec_valid, 0);
        check_eq("rst_fetch_ready", fetch_ready, 0);
        reset = 1'b0;
        stim_q.delete();
        fetch_valid = 1'b0;
        cycle();
        check_eq("rst_ready_rise", fetch_ready, 1);
        vprob = old_v;
        obs_pcs.delete();
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!dec_valid && (n < 20)) begin
            cycle();
            n++;
        end
        check_eq(tag, dec_valid, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        fetch_valid = 1'b0;
        fetch_exec_mask = '0;
        fetch_pc = '0;
        fetch_insn = '0;
        dec_ready = 1'b1;

        // Reset with fetch_valid held high
        do_reset();
        check_eq("rst_stall", stall_count, 0);
        check_eq("rst_halted", halted, 0);

        // Single ADD-class instruction, 1-cycle latency
        rprob = 100;
        vprob = 100;
        stim_q.push_back(mk(8'hFF, 64'h100, 32'hFFFE_4321));
        drive();
        cycle();
        check_eq("add_lat_early", dec_valid, 0);
        cycle();
        check_eq("add_valid", dec_valid, 1);
        check_eq("add_opc", dec_opcode, 8'h21);
        check_eq("add_rd", dec_rd, 4'h3);
        check_eq("add_rs1", dec_rs1, 4'h4);
        check_eq("add_rs2", dec_rs2, 4'hE);
        check_eq("add_imm", dec_imm, 64'hFFFF_FFFF_FFFF_FFFE);
        check_eq("add_branch", dec_is_branch, 0);
        check_eq("add_pc", dec_pc, 64'h100);
        check_eq("add_mask", dec_exec_mask, 8'hFF);
        repeat (2) cycle();

        // Back-pressure: 1 in output + 2 in FIFO, then refused
        do_reset();
        rprob = 0;
        for (int i = 0; i < 4; i++) stim_q.push_back(mk(8'(i + 1), 64'h1000 + 64'(i * 4), 32'h0000_1021 + 32'(i << 8)));
        drive();
        repeat (3) cycle();
        check_eq("bp_ready_low", fetch_ready, 0);
        check_eq("bp_valid", dec_valid, 1);
        check_eq("bp_stall1", stall_count, 1);
        repeat (4) cycle();
        check_eq("bp_stall5", stall_count, 5);
        check_eq("bp_still_low", fetch_ready, 0);
        rprob = 100;
        drive();
        for (int n = 0; n < 20 && (stim_q.size() > 0 || dec_valid); n++) cycle();
        check_eq("bp_drain_n", obs_pcs.size(), 4);
        for (int i = 0; i < 4 && i < obs_pcs.size(); i++) check_eq("bp_order", obs_pcs[i], 64'h1000 + 64'(i * 4));

        // Branch / control classification
        do_reset();
        stim_q.push_back(mk(8'h0F, 64'h300, 32'h0005_2311));
        stim_q.push_back(mk(8'h0F, 64'h304, 32'h0000_0002));
        drive();
        wait_valid("jeq_wait");
        check_eq("jeq_opc", dec_opcode, 8'h11);
        check_eq("jeq_branch", dec_is_branch, 1);
        check_eq("jeq_ctrl", dec_is_ctrl, 1);
        cycle();
        check_eq("lrpc_opc", dec_opcode, 8'h02);
        check_eq("lrpc_ctrl", dec_is_ctrl, 1);
        check_eq("lrpc_branch", dec_is_branch, 0);
        repeat (2) cycle();

        // HALT with a younger packet behind it
        do_reset();
        stim_q.push_back(mk(8'h01, 64'h200, 32'h0000_0001));
        stim_q.push_back(mk(8'h01, 64'h204, 32'h0000_0321));
        drive();
        repeat (6) cycle();
        check_eq("halt_halted", halted, 1);
        check_eq("halt_ready", fetch_ready, 0);
        check_eq("halt_valid", dec_valid, 0);
        check_eq("halt_n_out", obs_pcs.size(), 1);
        if (obs_pcs.size() > 0) check_eq("halt_pc", obs_pcs[0], 64'h200);
        stim_q.push_back(mk(8'h01, 64'h208, 32'h0000_0021));
        drive();
        repeat (3) cycle();
        check_eq("halt_no_accept", obs_pcs.size(), 1);
        do_reset();
        check_eq("halt_reset_clear", halted, 0);

        // Illegal opcode boundary
        stim_q.push_back(mk(8'h03, 64'h400, 32'h1234_5631));
        stim_q.push_back(mk(8'h03, 64'h404, 32'h1234_5632));
        drive();
        wait_valid("ill_wait");
        check_eq("max_legal", dec_illegal, 0);
        cycle();
        check_eq("ill_opc", dec_opcode, 8'h32);
        check_eq("ill_flag", dec_illegal, 1);
        repeat (2) cycle();

        // Stall counter saturation
        do_reset();
        rprob = 0;
        stim_q.push_back(mk(8'h01, 64'h500, 32'h0000_0021));
        drive();
        wait_valid("sat_wait");
        skip_stall = 1;
        force dut.stall_count_q = 32'hFFFF_FFF0;
        cycle();
        release dut.stall_count_q;
        repeat (30) cycle();
        check_eq("stall_sat", stall_count, 32'hFFFF_FFFF);
        m_stall = 32'hFFFF_FFFF;
        skip_stall = 0;
        repeat (3) cycle();
        check_eq("stall_hold", stall_count, 32'hFFFF_FFFF);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                vprob = int'($urandom_range(100, 30));
                rprob = int'($urandom_range(100, 20));
            end
            if (stim_q.size() < 3) stim_q.push_back(rand_pkt());
            if ((m_state == 2) || ($urandom_range(199) == 0)) do_reset();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
